// File: rtl/button_ctrl_pkg.sv
// Shared types and helpers for the button event path.
package button_ctrl_pkg;

  localparam int NR_OF_BUTTONS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } btn_arb_state_t;

  // Number of set bits in a vector of up to 16 buttons.
  function automatic logic [4:0] count_ones16(input logic [15:0] vec);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request after last_grant, wrapping.
module rr_arbiter
  import button_ctrl_pkg::*;
#(
  parameter int N  = NR_OF_BUTTONS,
  parameter int IW = $clog2(NR_OF_BUTTONS)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_req_o
);

  logic [IW-1:0] sel_s;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    sel_s = {IW{1'b0}};
    for (int k = N; k >= 1; k--) begin
      int cand;
      cand = (int'(last_grant_i) + k) % N;
      if (req_i[cand]) begin
        sel_s = IW'(cand);
      end else begin
        sel_s = sel_s;
      end
    end
    grant_idx_o = sel_s;
    any_req_o   = |req_i;
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects button toggle events, buffers one per button, and delivers them
// one at a time over a valid/ready output with round-robin fairness.
module button_event_arbiter
  import button_ctrl_pkg::*;
#(
  parameter int NR_OF_BUTTONS_P  = NR_OF_BUTTONS,
  parameter int MIN_GAP_CLKS_P   = 100000,
  parameter int LOST_CNT_WIDTH_P = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NR_OF_BUTTONS_P-1:0]         btn_tgl,
  output logic                               evt_valid,
  input  logic                               evt_ready,
  output logic [$clog2(NR_OF_BUTTONS_P)-1:0] evt_button,
  output logic                               evt_overrun,
  output logic [NR_OF_BUTTONS_P-1:0]         pending,
  output logic [LOST_CNT_WIDTH_P-1:0]        lost_cnt
);

  localparam int N        = NR_OF_BUTTONS_P;
  localparam int IDX_W    = $clog2(NR_OF_BUTTONS_P);
  localparam int GAP_W    = (MIN_GAP_CLKS_P > 1) ? $clog2(MIN_GAP_CLKS_P) : 1;
  localparam int GAP_LOAD = (MIN_GAP_CLKS_P > 0) ? MIN_GAP_CLKS_P - 1 : 0;
  localparam int SUM_W    = LOST_CNT_WIDTH_P + 5;
  localparam logic [LOST_CNT_WIDTH_P-1:0] LOST_MAX = {LOST_CNT_WIDTH_P{1'b1}};

  btn_arb_state_t              state_q, state_d;
  logic [N-1:0]                prev_tgl_q;
  logic [N-1:0]                pending_q, pending_d;
  logic [N-1:0]                overrun_q, overrun_d;
  logic [LOST_CNT_WIDTH_P-1:0] lost_cnt_q, lost_cnt_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic                        evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]            evt_button_q, evt_button_d;
  logic                        evt_overrun_q, evt_overrun_d;

  logic [N-1:0]     chg_s;
  logic [N-1:0]     grant_vec_s;
  logic [N-1:0]     lost_vec_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic             any_req_s;
  logic [SUM_W-1:0] lost_sum_s;

  assign chg_s = btn_tgl ^ prev_tgl_q;

  rr_arbiter #(.N(N), .IW(IDX_W)) u_rr (
    .req_i        (pending_q),
    .last_grant_i (last_grant_q),
    .grant_idx_o  (grant_idx_s),
    .any_req_o    (any_req_s)
  );

  // One-hot of the button being granted this cycle (only from IDLE).
  always_comb begin
    if ((state_q == IDLE) && any_req_s) begin
      grant_vec_s = {{(N-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      grant_vec_s = {N{1'b0}};
    end
  end

  // Per-button pending/overrun flags; a press on a granted button is a fresh event.
  always_comb begin
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    lost_vec_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_vec_s[i]) begin
        pending_d[i] = chg_s[i];
        overrun_d[i] = 1'b0;
      end else if (chg_s[i]) begin
        if (pending_q[i]) begin
          overrun_d[i]  = 1'b1;
          lost_vec_s[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
        end
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Saturating lost counter; several buttons may lose a press in the same cycle.
  always_comb begin
    lost_sum_s = SUM_W'(lost_cnt_q) + SUM_W'(count_ones16(16'(lost_vec_s)));
    if (lost_sum_s > SUM_W'(LOST_MAX)) begin
      lost_cnt_d = LOST_MAX;
    end else begin
      lost_cnt_d = lost_sum_s[LOST_CNT_WIDTH_P-1:0];
    end
  end

  // Delivery FSM: grant in IDLE, hold in SEND until accepted, then pace in GAP.
  always_comb begin
    state_d       = state_q;
    evt_valid_d   = evt_valid_q;
    evt_button_d  = evt_button_q;
    evt_overrun_d = evt_overrun_q;
    last_grant_d  = last_grant_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          evt_valid_d   = 1'b1;
          evt_button_d  = grant_idx_s;
          evt_overrun_d = overrun_q[grant_idx_s];
          last_grant_d  = grant_idx_s;
          state_d       = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
          if (MIN_GAP_CLKS_P == 0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = GAP_W'(GAP_LOAD);
            state_d   = GAP;
          end
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = {GAP_W{1'b0}};
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any in-flight event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_tgl_q    <= {N{1'b0}};
      pending_q     <= {N{1'b0}};
      overrun_q     <= {N{1'b0}};
      lost_cnt_q    <= {LOST_CNT_WIDTH_P{1'b0}};
      last_grant_q  <= IDX_W'(N - 1);
      gap_cnt_q     <= {GAP_W{1'b0}};
      evt_valid_q   <= 1'b0;
      evt_button_q  <= {IDX_W{1'b0}};
      evt_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_tgl_q    <= btn_tgl;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      lost_cnt_q    <= lost_cnt_d;
      last_grant_q  <= last_grant_d;
      gap_cnt_q     <= gap_cnt_d;
      evt_valid_q   <= evt_valid_d;
      evt_button_q  <= evt_button_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_button  = evt_button_q;
  assign evt_overrun = evt_overrun_q;
  assign pending     = pending_q;
  assign lost_cnt    = lost_cnt_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench: two instances (gap 0 / lost width 2, gap 5 / lost width 16) share
// stimulus; a behavioural model checks both every cycle, plus directed vectors.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int BW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  btn_tgl;
  logic          evt_ready;

  logic          a_valid, b_valid;
  logic [BW-1:0] a_button, b_button;
  logic          a_ovr, b_ovr;
  logic [N-1:0]  a_pend, b_pend;
  logic [1:0]    a_lost;
  logic [15:0]   b_lost;

  int checks   = 0;
  int failures = 0;

  button_event_arbiter #(.NR_OF_BUTTONS_P(N), .MIN_GAP_CLKS_P(0), .LOST_CNT_WIDTH_P(2)) dut_a (
    .clk(clk), .rst(rst), .btn_tgl(btn_tgl), .evt_valid(a_valid), .evt_ready(evt_ready),
    .evt_button(a_button), .evt_overrun(a_ovr), .pending(a_pend), .lost_cnt(a_lost));

  button_event_arbiter #(.NR_OF_BUTTONS_P(N), .MIN_GAP_CLKS_P(5), .LOST_CNT_WIDTH_P(16)) dut_b (
    .clk(clk), .rst(rst), .btn_tgl(btn_tgl), .evt_valid(b_valid), .evt_ready(evt_ready),
    .evt_button(b_button), .evt_overrun(b_ovr), .pending(b_pend), .lost_cnt(b_lost));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-button flags, a pending output slot and the
  // earliest cycle at which a new grant is allowed after a handshake.
  int           gap_cfg[2]  = '{0, 5};
  int           lost_max[2] = '{3, 65535};
  logic [N-1:0] m_prev[2];
  bit           m_pend[2][N];
  bit           m_ovr[2][N];
  int           m_lost[2];
  bit           m_valid[2];
  int           m_btn[2];
  bit           m_eovr[2];
  int           m_last[2];
  int           m_ready_at[2];
  int           cyc = 0;

  function automatic int next_grant_delay(int gap);
    if (gap == 0) return 1;
    if (gap == 1) return 2;
    return gap;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = '0;
      for (int i = 0; i < N; i++) begin
        m_pend[k][i] = 1'b0;
        m_ovr[k][i]  = 1'b0;
      end
      m_lost[k] = 0; m_valid[k] = 1'b0; m_btn[k] = 0; m_eovr[k] = 1'b0;
      m_last[k] = N - 1; m_ready_at[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] chg;
      int g;
      chg = btn_tgl ^ m_prev[k];
      g = -1;
      if (!m_valid[k] && cyc >= m_ready_at[k]) begin
        for (int j = 1; j <= N; j++) begin
          if (g < 0 && m_pend[k][(m_last[k] + j) % N]) g = (m_last[k] + j) % N;
        end
      end
      if (m_valid[k] && evt_ready) begin
        m_valid[k] = 1'b0;
        m_ready_at[k] = cyc + next_grant_delay(gap_cfg[k]);
      end
      if (g >= 0) begin
        m_valid[k] = 1'b1; m_btn[k] = g; m_eovr[k] = m_ovr[k][g]; m_last[k] = g;
      end
      for (int i = 0; i < N; i++) begin
        if (i == g) begin
          m_pend[k][i] = chg[i];
          m_ovr[k][i]  = 1'b0;
        end else if (chg[i]) begin
          if (m_pend[k][i]) begin
            m_ovr[k][i] = 1'b1;
            if (m_lost[k] < lost_max[k]) m_lost[k]++;
          end else begin
            m_pend[k][i] = 1'b1;
          end
        end
      end
      m_prev[k] = btn_tgl;
    end
  endtask

  task automatic check_models();
    for (int k = 0; k < 2; k++) begin
      logic v, o;
      int b, l;
      logic [N-1:0] p, mp;
      if (k == 0) begin v = a_valid; b = a_button; o = a_ovr; p = a_pend; l = a_lost; end
      else        begin v = b_valid; b = b_button; o = b_ovr; p = b_pend; l = b_lost; end
      for (int i = 0; i < N; i++) mp[i] = m_pend[k][i];
      checks++;
      if (v !== m_valid[k] || p !== mp || l != m_lost[k] ||
          (m_valid[k] && (b != m_btn[k] || o !== m_eovr[k]))) begin
        failures++;
        $display("FAIL model_dut%0d cyc=%0d got v=%0b btn=%0d ovr=%0b pend=%b lost=%0d want v=%0b btn=%0d ovr=%0b pend=%b lost=%0d",
                 k, cyc, v, b, o, p, l, m_valid[k], m_btn[k], m_eovr[k], mp, m_lost[k]);
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then sample on the falling edge.
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_models();
  endtask

  task automatic expect_bit(string name, logic got, logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  task automatic expect_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [N-1:0] tgl;
    logic         rdy;
    logic         v;
    int           btn;
    logic         ovr;
    logic [N-1:0] pend;
    int           lost;
  } vec_t;

  vec_t vt[28];

  initial begin
    int first, sec, seen;

    // inputs applied for one cycle, then outputs expected from dut_a (gap 0, 2-bit lost counter)
    vt[0]  = '{4'b0100, 1'b1, 1'b0, 0, 1'b0, 4'b0100, 0};
    vt[1]  = '{4'b0100, 1'b1, 1'b1, 2, 1'b0, 4'b0000, 0};
    vt[2]  = '{4'b0100, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 0};
    vt[3]  = '{4'b0100, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 0};
    vt[4]  = '{4'b1011, 1'b1, 1'b0, 0, 1'b0, 4'b1111, 0};
    vt[5]  = '{4'b1011, 1'b1, 1'b1, 3, 1'b0, 4'b0111, 0};
    vt[6]  = '{4'b1011, 1'b1, 1'b0, 0, 1'b0, 4'b0111, 0};
    vt[7]  = '{4'b1011, 1'b1, 1'b1, 0, 1'b0, 4'b0110, 0};
    vt[8]  = '{4'b1011, 1'b1, 1'b0, 0, 1'b0, 4'b0110, 0};
    vt[9]  = '{4'b1011, 1'b1, 1'b1, 1, 1'b0, 4'b0100, 0};
    vt[10] = '{4'b1011, 1'b1, 1'b0, 0, 1'b0, 4'b0100, 0};
    vt[11] = '{4'b1011, 1'b1, 1'b1, 2, 1'b0, 4'b0000, 0};
    vt[12] = '{4'b1011, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 0};
    vt[13] = '{4'b1001, 1'b0, 1'b0, 0, 1'b0, 4'b0010, 0};
    vt[14] = '{4'b1011, 1'b0, 1'b1, 1, 1'b0, 4'b0010, 0};
    vt[15] = '{4'b1001, 1'b0, 1'b1, 1, 1'b0, 4'b0010, 1};
    vt[16] = '{4'b1001, 1'b1, 1'b0, 0, 1'b0, 4'b0010, 1};
    vt[17] = '{4'b1001, 1'b1, 1'b1, 1, 1'b1, 4'b0000, 1};
    vt[18] = '{4'b1001, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1};
    vt[19] = '{4'b1000, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 1};
    vt[20] = '{4'b1001, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 1};
    vt[21] = '{4'b1000, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 2};
    vt[22] = '{4'b1001, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 3};
    vt[23] = '{4'b1000, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 3};
    vt[24] = '{4'b1001, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 3};
    vt[25] = '{4'b1001, 1'b1, 1'b0, 0, 1'b0, 4'b0001, 3};
    vt[26] = '{4'b1001, 1'b1, 1'b1, 0, 1'b1, 4'b0000, 3};
    vt[27] = '{4'b1001, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 3};

    rst = 1'b1; btn_tgl = '0; evt_ready = 1'b1;
    model_reset();
    @(negedge clk);
    tick(); tick();

    // reset state
    expect_bit("rst_valid", a_valid, 1'b0);
    expect_int("rst_button", a_button, 0);
    expect_bit("rst_overrun", a_ovr, 1'b0);
    expect_int("rst_pending", a_pend, 0);
    expect_int("rst_lost", a_lost, 0);
    expect_bit("rst_valid_b", b_valid, 1'b0);

    rst = 1'b0;
    tick(); tick();

    // directed table: single press, round robin, backpressure/overrun, saturation
    for (int r = 0; r < 28; r++) begin
      btn_tgl = vt[r].tgl; evt_ready = vt[r].rdy;
      tick();
      checks++;
      if (a_valid !== vt[r].v || a_pend !== vt[r].pend || int'(a_lost) != vt[r].lost ||
          (vt[r].v && (int'(a_button) != vt[r].btn || a_ovr !== vt[r].ovr))) begin
        failures++;
        $display("FAIL vec%0d got v=%0b btn=%0d ovr=%0b pend=%b lost=%0d want v=%0b btn=%0d ovr=%0b pend=%b lost=%0d",
                 r, a_valid, a_button, a_ovr, a_pend, a_lost,
                 vt[r].v, vt[r].btn, vt[r].ovr, vt[r].pend, vt[r].lost);
      end
    end

    // gap enforcement on dut_b: second valid exactly 6 cycles after the first handshake
    rst = 1'b1; btn_tgl = '0; model_reset();
    tick();
    rst = 1'b0; evt_ready = 1'b1;
    tick(); tick();
    btn_tgl = 4'b0101;
    first = -1;
    for (int n = 0; n < 10 && first < 0; n++) begin
      tick();
      if (b_valid) first = cyc;
    end
    expect_bit("gap_first_seen", first >= 0, 1'b1);
    expect_int("gap_first_button", b_button, 0);
    sec = -1;
    for (int n = 0; n < 20 && sec < 0; n++) begin
      tick();
      if (b_valid) sec = cyc;
    end
    expect_bit("gap_second_seen", sec >= 0, 1'b1);
    expect_int("gap_distance", sec - first, 6);
    expect_int("gap_second_button", b_button, 2);
    for (int n = 0; n < 8; n++) tick();

    // reset while an event is in flight
    btn_tgl = 4'b0000; evt_ready = 1'b0;
    tick(); tick();
    expect_bit("midsend_valid_pre", a_valid, 1'b1);
    expect_int("midsend_pend_pre", a_pend, 4'b0100);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    expect_bit("midsend_valid_a", a_valid, 1'b0);
    expect_int("midsend_pend_a", a_pend, 0);
    expect_bit("midsend_valid_b", b_valid, 1'b0);
    expect_int("midsend_pend_b", b_pend, 0);
    @(negedge clk);
    tick();
    rst = 1'b0; evt_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (a_valid || b_valid) seen++;
    end
    expect_int("after_reset_no_event", seen, 0);

    // random traffic, mostly ready
    for (int n = 0; n < 1500; n++) begin
      logic [N-1:0] f;
      for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 3) == 0);
      btn_tgl = btn_tgl ^ f;
      evt_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    // random traffic, heavy backpressure to drive overruns and saturation
    for (int n = 0; n < 500; n++) begin
      logic [N-1:0] f;
      for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 2) == 0);
      btn_tgl = btn_tgl ^ f;
      evt_ready = ($urandom_range(0, 9) < 2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
